// File: rtl/jisp_frame_ctrl.sv
// Frame sequencer in front of the JPEG ISP pipeline: admits exactly one sensor frame per
// capture request and tracks it until drained. Optional drain watchdog: JISP_FRAME_CTRL_TIMEOUT_EN.
module jisp_frame_ctrl #(
  parameter  int SENSOR_X_SIZE = 1280,
  parameter  int SENSOR_Y_SIZE = 720,
  localparam int XW            = $clog2(SENSOR_X_SIZE),
  localparam int YW            = $clog2(SENSOR_Y_SIZE),
  localparam int CW            = XW + YW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] x_size_m1,
  input  logic [YW-1:0] y_size_m1,
  input  logic          frame_valid_in,
  input  logic          line_valid_in,
  input  logic          rgb24_valid_in,
  input  logic          rgb24_hold,
  output logic          frame_valid_out,
  output logic          line_valid_out,
  output logic          rgb24_valid_out,
  input  logic          di_valid,
  input  logic          di_hold,
  output logic          pipe_flush,
  output logic          busy,
  output logic          done,
  output logic [2:0]    err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT_SOF = 3'd2,
    S_CAPTURE  = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic          flush_nxt;
  logic          fv_q, lv_q;
  logic          fv_rise, fv_fall, lv_fall;
  logic          gate, checking, line_end, start_ok;
  logic          pix_hit, line_bad, frame_bad, ovf, beat, drain_hit, wd_expire;
  logic [2:0]    err_set;
  logic          err_hit;
  logic [XW-1:0] x_lat;
  logic [YW-1:0] y_lat;
  logic [XW:0]   pix_cnt;
  logic [YW:0]   line_cnt, line_total;
  logic [CW-1:0] blk_cnt, rows_tgt;
  logic [CW-1:0] mcu_x, mcu_y, rows_nxt;

  assign fv_rise  = frame_valid_in & ~fv_q;
  assign fv_fall  = ~frame_valid_in & fv_q;
  assign lv_fall  = ~line_valid_in & lv_q;
  assign start_ok = (state == S_IDLE) & start & ~abort;

  // The rising-edge cycle of WAIT_SOF is already open so the first pixel reaches the pipeline.
  assign gate = ~reset & ~abort &
                ((state == S_CAPTURE) | ((state == S_WAIT_SOF) & fv_rise));

  assign frame_valid_out = frame_valid_in & gate;
  assign line_valid_out  = line_valid_in  & gate;
  assign rgb24_valid_out = rgb24_valid_in & gate;

  assign checking   = (state == S_CAPTURE);
  assign line_end   = checking & lv_fall;
  assign pix_hit    = gate & rgb24_valid_in & line_valid_in;
  assign line_bad   = line_end & (pix_cnt != ({1'b0, x_lat} + (XW+1)'(1)));
  // Line increment from this same cycle is folded in before the frame compare.
  assign line_total = line_cnt + (YW+1)'(line_end);
  assign frame_bad  = checking & fv_fall & (line_total != ({1'b0, y_lat} + (YW+1)'(1)));
  assign ovf        = rgb24_valid_out & rgb24_hold;
  assign beat       = di_valid & ~di_hold;
  assign drain_hit  = (state == S_DRAIN) &
                      (({1'b0, blk_cnt} + (CW+1)'(beat)) >= {1'b0, rows_tgt});

  assign err_set = {frame_bad | wd_expire, line_bad, ovf};
  assign err_hit = |err_set;

  // One 4:2:0 MCU (16x16) emits 48 block rows; partial MCUs are padded.
  assign mcu_x    = CW'(x_size_m1 >> 4) + CW'(1);
  assign mcu_y    = CW'(y_size_m1 >> 4) + CW'(1);
  assign rows_nxt = mcu_x * mcu_y * CW'(48);

`ifdef JISP_FRAME_CTRL_TIMEOUT_EN
  logic [23:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if ((state != S_DRAIN) || beat) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 24'd1;
    end
  end

  assign wd_expire = (state == S_DRAIN) & (wd_cnt == 24'hFF_FFFF);
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    flush_nxt = 1'b0;
    case (state)
      S_IDLE:     if (start_ok) state_nxt = S_ARM;
      S_ARM:      if (!frame_valid_in) state_nxt = S_WAIT_SOF;
      S_WAIT_SOF: if (fv_rise) state_nxt = S_CAPTURE;
      S_CAPTURE:  if (fv_fall) state_nxt = S_DRAIN;
      S_DRAIN:    if (drain_hit) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    // Abort and freshly detected errors override every normal transition, including completion.
    if ((state != S_IDLE) && (abort || err_hit)) begin
      state_nxt = S_IDLE;
      flush_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pipe_flush <= 1'b0;
      fv_q       <= 1'b0;
      lv_q       <= 1'b0;
      err        <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      blk_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      pipe_flush <= flush_nxt;
      fv_q       <= frame_valid_in;
      lv_q       <= line_valid_in;
      if (start_ok) begin
        err      <= '0;
        pix_cnt  <= '0;
        line_cnt <= '0;
        blk_cnt  <= '0;
      end else begin
        if (!abort) err <= err | err_set;
        if (line_end) begin
          pix_cnt  <= '0;
          line_cnt <= line_total;
        end else if (pix_hit) begin
          pix_cnt  <= pix_cnt + (XW+1)'(1);
        end
        if (((state == S_CAPTURE) || (state == S_DRAIN)) && beat) blk_cnt <= blk_cnt + CW'(1);
      end
    end
  end

  // Frame geometry is only consumed after a start has loaded it.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      x_lat    <= x_size_m1;
      y_lat    <= y_size_m1;
      rows_tgt <= rows_nxt;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_jisp_frame_ctrl.sv
// Randomized scoreboard bench for jisp_frame_ctrl: plans whole frames, predicts the
// terminating event (done or flush) from frame rules, and a monitor checks each event.
module tb_jisp_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [10:0] x_size_m1;
  logic [9:0]  y_size_m1;
  logic        frame_valid_in, line_valid_in, rgb24_valid_in, rgb24_hold;
  logic        frame_valid_out, line_valid_out, rgb24_valid_out;
  logic        di_valid, di_hold;
  logic        pipe_flush, busy, done;
  logic [2:0]  err;

  always #5 clk = ~clk;

  jisp_frame_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .x_size_m1(x_size_m1), .y_size_m1(y_size_m1),
    .frame_valid_in(frame_valid_in), .line_valid_in(line_valid_in),
    .rgb24_valid_in(rgb24_valid_in), .rgb24_hold(rgb24_hold),
    .frame_valid_out(frame_valid_out), .line_valid_out(line_valid_out),
    .rgb24_valid_out(rgb24_valid_out),
    .di_valid(di_valid), .di_hold(di_hold),
    .pipe_flush(pipe_flush), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    bit is_done;
    int err;
    int pix;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  pix_acc = 0;
  bit  mon_en = 0;

  // Frame plan shared by the model and the driver
  int  lens[$];
  int  xm1, ym1;
  int  hold_l, hold_p, abort_l, abort_p;
  bit  in_pre;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rows(input int x, input int y);
    return ((x / 16) + 1) * ((y / 16) + 1) * 48;
  endfunction

  // Walk the planned frame pixel by pixel and decide how the capture ends.
  function automatic ev_t model();
    ev_t e;
    int  pix;
    pix = 0;
    e.is_done = 1'b0;
    e.err = 0;
    e.pix = 0;
    for (int l = 0; l < lens.size(); l++) begin
      for (int p = 0; p < lens[l]; p++) begin
        if (l == abort_l && p == abort_p) begin
          e.pix = pix;
          return e;
        end
        pix++;
        if (l == hold_l && p == hold_p) begin
          e.err = 1;
          e.pix = pix;
          return e;
        end
      end
      if (lens[l] != xm1 + 1) begin
        e.err = 2;
        e.pix = pix;
        return e;
      end
    end
    e.pix = pix;
    if (lens.size() != ym1 + 1) e.err = 4;
    else e.is_done = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (rgb24_valid_out) pix_acc++;
      if (done || pipe_flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_done", int'(done), int'(e.is_done));
          chk("ev_flush", int'(pipe_flush), int'(!e.is_done));
          chk("ev_err", int'(err), e.err);
          chk("ev_pixels", pix_acc, e.pix);
          chk("ev_busy", int'(busy), int'(e.is_done));
        end
        pix_acc = 0;
      end
    end
  end

  task automatic drive_line(input int l, input int len, input bit no_gap_first);
    for (int p = 0; p < len; p++) begin
      if (!(no_gap_first && p == 0) && ($urandom_range(0, 3) == 0)) begin
        line_valid_in  = 1'b1;
        rgb24_valid_in = 1'b0;
        rgb24_hold     = 1'($urandom_range(0, 1));
        tick();
      end
      line_valid_in  = 1'b1;
      rgb24_valid_in = 1'b1;
      rgb24_hold     = in_pre ? 1'($urandom_range(0, 1)) : (l == hold_l && p == hold_p);
      abort          = !in_pre && (l == abort_l) && (p == abort_p);
      tick();
      abort          = 1'b0;
      rgb24_hold     = 1'b0;
      rgb24_valid_in = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int kind, nl, sl, r, cnt;
    bit pre, simul, rise_px;
    int fixed_kind[5] = '{0, 0, 1, 2, 3};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    x_size_m1 = '0; y_size_m1 = '0;
    frame_valid_in = 1'b1; line_valid_in = 1'b1; rgb24_valid_in = 1'b1; rgb24_hold = 1'b0;
    di_valid = 1'b0; di_hold = 1'b0; in_pre = 1'b0;
    tick(); tick();
    chk("rst_frame_valid_out", int'(frame_valid_out), 0);
    chk("rst_line_valid_out", int'(line_valid_out), 0);
    chk("rst_rgb24_valid_out", int'(rgb24_valid_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pipe_flush", int'(pipe_flush), 0);
    chk("rst_err", int'(err), 0);
    frame_valid_in = 1'b0; line_valid_in = 1'b0; rgb24_valid_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    mon_en = 1'b1;

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start_busy", int'(busy), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("abort_in_idle_busy", int'(busy), 0);

    for (int it = 0; it < 16; it++) begin
      kind = (it < 5) ? fixed_kind[it] : ((it == 5) ? 4 : $urandom_range(0, 4));
      if (it < 5) begin
        xm1 = 31; ym1 = 15;
      end else begin
        xm1 = $urandom_range(3, 19) * 2 + 1;
        ym1 = $urandom_range(3, 11) * 2 + 1;
      end
      pre     = (it == 1) || (it >= 5 && $urandom_range(0, 3) == 0);
      simul   = 1'($urandom_range(0, 1));
      rise_px = 1'($urandom_range(0, 1));
      hold_l = -1; hold_p = -1; abort_l = -1; abort_p = -1;
      nl = ym1 + 1;
      if (kind == 4) nl = ($urandom_range(0, 1) == 1) ? ym1 - 1 : ym1 + 3;
      lens.delete();
      for (int l = 0; l < nl; l++) lens.push_back(xm1 + 1);
      case (kind)
        1: begin
          sl = (it == 2) ? 3 : $urandom_range(0, nl - 1);
          if (it == 2) lens[sl] = 30;
          else lens[sl] = ($urandom_range(0, 1) == 1) ? xm1 + 2 : xm1 + 1 - $urandom_range(1, 3);
        end
        2: begin
          hold_l = $urandom_range(0, nl - 1);
          hold_p = $urandom_range(0, xm1);
        end
        3: begin
          abort_l = 4;
          abort_p = $urandom_range(0, xm1);
        end
        default: ;
      endcase

      if (pre) begin
        frame_valid_in = 1'b1;
        tick();
        in_pre = 1'b1;
        drive_line(-1, xm1 + 1, 1'b0);
        line_valid_in = 1'b0;
        tick();
        x_size_m1 = 11'(xm1); y_size_m1 = 10'(ym1);
        start = 1'b1;
        exp_q.push_back(model());
        tick();
        start = 1'b0;
        tick();
        drive_line(-1, xm1 + 1, 1'b0);
        line_valid_in = 1'b0;
        tick();
        frame_valid_in = 1'b0;
        in_pre = 1'b0;
        tick(); tick(); tick();
      end else begin
        x_size_m1 = 11'(xm1); y_size_m1 = 10'(ym1);
        start = 1'b1;
        exp_q.push_back(model());
        tick();
        start = 1'b0;
        tick(); tick(); tick();
      end
      x_size_m1 = 11'($urandom_range(0, 2047));
      y_size_m1 = 10'($urandom_range(0, 1023));

      frame_valid_in = 1'b1;
      if (!rise_px) begin
        tick(); tick();
      end
      for (int l = 0; l < nl; l++) begin
        drive_line(l, lens[l], (l == 0) && rise_px);
        if (l == nl - 1 && simul) begin
          line_valid_in = 1'b0; frame_valid_in = 1'b0;
          tick();
        end else begin
          line_valid_in = 1'b0;
          if (kind == 0 && l < nl - 1 && $urandom_range(0, 3) == 0) start = 1'b1;
          tick();
          start = 1'b0;
          tick();
        end
      end
      if (!simul) begin
        frame_valid_in = 1'b0;
        tick();
      end
      tick(); tick();

      if (kind == 0) begin
        if (it == 0 || $urandom_range(0, 3) == 0) begin
          repeat (40) tick();
          chk("busy_while_drain_stalled", int'(busy), 1);
        end
        r = rows(xm1, ym1);
        cnt = 0;
        while (cnt < r) begin
          di_valid = ($urandom_range(0, 3) != 0);
          di_hold  = ($urandom_range(0, 3) == 0);
          if (di_valid && !di_hold) cnt++;
          tick();
        end
        di_valid = 1'b0; di_hold = 1'b0;
        chk("done_after_last_beat", int'(done), 1);
      end
      wait_idle();
      repeat (3) tick();
    end

    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jisp_frame_ctrl.md
# jisp_frame_ctrl

Frame sequencer sitting in front of the JPEG ISP pipeline (rgb2yuv → subsample → mcu_buffer). It arms on a capture request, waits for a clean sensor frame boundary, and admits exactly one frame into the pipeline by gating the sensor valid and frame/line strobes. It checks line length, line count and input overflow, then counts 8-pixel block rows leaving the pipeline until the frame has fully drained. It reports done or error status to the capture controller.

## Interface
Parameters:
- SENSOR_X_SIZE, 1280: maximum frame width; XW = $clog2(SENSOR_X_SIZE)
- SENSOR_Y_SIZE, 720: maximum frame height; YW = $clog2(SENSOR_Y_SIZE)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- start  in  1  capture request pulse; honoured only in IDLE
- abort  in  1  cancel capture; highest priority
- x_size_m1  in  XW  frame width minus 1; odd value required
- y_size_m1  in  YW  frame height minus 1; odd value required
- frame_valid_in, line_valid_in, rgb24_valid_in  in  1 each  sensor strobes
- rgb24_hold  in  1  pipeline input backpressure
- frame_valid_out, line_valid_out, rgb24_valid_out  out  1 each  gated strobes to the pipeline
- di_valid, di_hold  in  1 each  pipeline output handshake, observed only
- pipe_flush  out  1  one-cycle pulse to flush the pipeline after an abort or error
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the frame has fully drained
- err  out  3  sticky error flags: [0] overflow, [1] line length, [2] line count; cleared on start

## Operation
- x_size_m1 and y_size_m1 are latched on an accepted start.
- Expected block rows: R = ((x_size_m1>>4)+1) × ((y_size_m1>>4)+1) × 48, one 4:2:0 MCU per 16×16 pixels with partial MCUs padded. Counter width is XW+YW.
- States and transitions:
  - IDLE → ARM on start.
  - ARM → WAIT_SOF when frame_valid_in is low, so that a frame already in progress is skipped.
  - WAIT_SOF → CAPTURE on the rising edge of frame_valid_in.
  - CAPTURE → DRAIN on the falling edge of frame_valid_in.
  - DRAIN → DONE when the count of di_valid && !di_hold beats reaches R.
  - DONE → IDLE after one cycle.
- Gating: each *_out equals the matching *_in AND the gate. The gate is high in CAPTURE, and also in the rising-edge cycle of WAIT_SOF, so the first pixel is not lost. Data bits bypass this block.
- Pixel counter:
  - Counts rgb24_valid_in && line_valid_in while gated.
  - On the falling edge of line_valid_in: if count ≠ x_size_m1+1, set err[1]; then reset the count.
- Line counter:
  - Increments on each falling edge of line_valid_in.
  - On the falling edge of frame_valid_in: if count ≠ y_size_m1+1, set err[2].
- Overflow: rgb24_valid_out && rgb24_hold in any cycle sets err[0]. The sensor cannot stall.
- Any err bit set in CAPTURE or DRAIN:
  - go to IDLE immediately and close the gate;
  - pulse pipe_flush;
  - done is not asserted.
- abort in any non-IDLE state: go to IDLE, close the gate, pulse pipe_flush, leave err unchanged. abort in IDLE has no effect.
- start outside IDLE is ignored.

## Timing
- Reset values: state IDLE; busy 0; done 0; pipe_flush 0; err 0; all counters 0. All gated outputs are 0 while in reset.
- Gating is combinational and adds zero latency. State, counters and flags are registered.
- Edge detection uses one registered copy of frame_valid_in and line_valid_in. Edges are seen in the cycle the input changes.
- busy rises the cycle after start. done rises on the cycle after the R-th block row beat and lasts exactly one cycle. busy falls together with done.
- A line falling edge and a frame falling edge in the same cycle are processed together. The line check and line increment are evaluated before the frame compare.
- abort and start in the same cycle in IDLE: abort wins, start is dropped.
- abort on the same cycle as the DRAIN completion: abort wins, no done.

## Configuration
- JISP_FRAME_CTRL_TIMEOUT_EN:
  - Defined: adds a 24-bit drain watchdog, cleared on every counted di beat.
  - If the watchdog reaches 2^24−1 in DRAIN, it sets err bit [2] (shared line-count/timeout flag), pulses pipe_flush and returns to IDLE.
  - Undefined: no watchdog; DRAIN waits indefinitely.

## Test plan
- 32×16 frame, no hold, di drained freely → exactly 32 pixels per line gated, R = 2×1×48 = 96 beats, then done pulses once; err = 0.
- start while frame_valid_in is already high → that frame stays fully gated off; capture begins on the next rising edge.
- One line of 30 pixels in a 32×16 frame → err[1] set, pipe_flush pulse, return to IDLE, no done.
- rgb24_hold asserted during a valid pixel → err[0] set within the same cycle, busy falls on the next cycle.
- abort mid-CAPTURE on line 5 → gates drop the same cycle, pipe_flush pulses, err stays 0; a new start then captures a clean frame.
- With the macro defined, DRAIN with di_valid held low → err[2] after 2^24−1 cycles; with the macro undefined, busy stays high.
